seq_alu: RTL and testbench

Parametrised, handshaked ALU that succeeds the combinational 16-bit, 3-bit-opcode ALU. It adds registered outputs, valid/ready flow control on both sides, a multi-cycle shift-add multiplier and an internal accumulator. It sits between an operand source (sequencer or testbench driver) and a result consumer. It is the datapath core for the upcoming multi-cycle processor work.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_mul.sv | 54 +++++
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings OP_ADD..OP_ACC (3-bit)
//   - FSM state encoding ST_IDLE / ST_BUSY
//   - bit positions of C/Z/V inside the packed flag register
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ACC = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle of the sequential ALU.
//   master : operand source + result consumer (drives operands, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result, flags)
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output in_valid, a, b, cin, opc, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_v
  );

  modport slave (
    input  in_valid, a, b, cin, opc, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_v
  );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, async active-low reset (clears the step counter)
//   start      : load a/b and begin (count = WIDTH)
//   a, b       : unsigned operands
//   done       : high in the cycle whose edge completes the last step
//   product    : full 2*WIDTH product, valid while done is high
// The final partial product is added combinationally on the done cycle,
// so the full product is available WIDTH edges after start.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod_nxt;

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign done     = (cnt == CW'(1));
  assign product  = prod_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Datapath regs carry no reset; they are only consulted while cnt != 0.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (cnt != '0) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result, accumulator and a
// multi-cycle multiplier.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_alu_if.slave -- in_valid/in_ready/a/b/cin/opc on the
//                operand side, out_valid/out_ready/result/flag_c/z/v on
//                the result side
// Ops 0-5 and 7 produce a result one edge after accept; MUL holds the
// block in BUSY for WIDTH edges.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  state_t             state;
  logic               vld_p1;
  logic [WIDTH-1:0]   res_p1;
  logic [2:0]         flg_p1;
  logic [WIDTH-1:0]   acc;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   res_n;
  logic [WIDTH-1:0]   acc_base;
  logic               c_n;
  logic               v_n;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return ((x < 0) != (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  function automatic logic [2:0] pack_flags(input logic c, input logic z,
                                            input logic v);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign bus.in_ready  = rst_n && (state == ST_IDLE) && (!vld_p1 || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign mul_start     = accept && (bus.opc == OP_MUL);
  assign bus.out_valid = vld_p1;
  assign bus.result    = res_p1;
  assign bus.flag_c    = flg_p1[FLAG_C];
  assign bus.flag_z    = flg_p1[FLAG_Z];
  assign bus.flag_v    = flg_p1[FLAG_V];

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Stage p0: single-cycle combinational unit on the live operands.
  always_comb begin
    ext      = '0;
    res_n    = '0;
    c_n      = 1'b0;
    v_n      = 1'b0;
    acc_base = bus.cin ? '0 : acc;
    case (bus.opc)
      OP_ADD: begin
        ext   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
        v_n   = add_ovf(bus.a, bus.b, res_n);
      end
      OP_SUB: begin
        ext   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
        v_n   = sub_ovf(bus.a, bus.b, res_n);
      end
      OP_AND: res_n = bus.a & bus.b;
      OP_OR:  res_n = bus.a | bus.b;
      OP_XOR: res_n = bus.a ^ bus.b;
      OP_SLL: begin
        // Top bit of the widened shift is the last bit shifted out (0 for shift 0).
        ext   = {1'b0, bus.a} << bus.b[SHW-1:0];
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
      end
      OP_ACC: begin
        ext   = {1'b0, acc_base} + {1'b0, bus.a};
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
        v_n   = add_ovf(bus.a, acc_base, res_n);
      end
      default: ;
    endcase
  end

  // Stage p1: FSM, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      flg_p1 <= '0;
      acc    <= '0;
    end else begin
      if (bus.out_ready) vld_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.opc == OP_MUL) begin
              state <= ST_BUSY;
            end else begin
              res_p1 <= res_n;
              flg_p1 <= pack_flags(c_n, res_n == '0, v_n);
              vld_p1 <= 1'b1;
              if (bus.opc == OP_ACC) acc <= res_n;
            end
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            res_p1 <= mul_prod[WIDTH-1:0];
            flg_p1 <= pack_flags(mul_prod[2*WIDTH-1:WIDTH] != '0,
                                 mul_prod[WIDTH-1:0] == '0, 1'b0);
            vld_p1 <= 1'b1;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=16.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   stray;

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] av,
                       input logic [15:0] bv, input logic c);
    bus.in_valid = 1'b1;
    bus.opc      = op;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
  endtask

  // Packed {C,Z,V} as seen on the ports.
  function automatic logic [2:0] flags();
    return {bus.flag_c, bus.flag_z, bus.flag_v};
  endfunction

  task automatic chk_out(input string tag, input logic [15:0] r, input logic [2:0] f);
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, r});
    chk({tag, "_flg"}, {29'd0, flags()}, {29'd0, f});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opc       = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_res", {16'd0, bus.result}, 32'd0);
    chk("rst_flg", {29'd0, flags()}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back single-cycle ops
    drive(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    tick();
    chk_out("add_wrap", 16'h0000, 3'b110);
    drive(OP_SUB, 16'h8000, 16'h0001, 1'b0);
    tick();
    chk_out("sub_ovf", 16'h7FFF, 3'b001);
    drive(OP_SLL, 16'h8001, 16'h0001, 1'b0);
    tick();
    chk_out("sll1", 16'h0002, 3'b100);
    chk("b2b_rdy", {31'd0, bus.in_ready}, 32'd1);
    drive(OP_SUB, 16'h0000, 16'h0001, 1'b0);
    tick();
    chk_out("sub_wrap", 16'hFFFF, 3'b100);
    drive(OP_SLL, 16'hABCD, 16'h0010, 1'b0);
    tick();
    chk_out("sll0", 16'hABCD, 3'b000);
    drive(OP_AND, 16'hF0F0, 16'hFF00, 1'b0);
    tick();
    chk_out("and", 16'hF000, 3'b000);
    drive(OP_XOR, 16'h5A5A, 16'h5A5A, 1'b1);
    tick();
    chk_out("xor_z", 16'h0000, 3'b010);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_vld", {31'd0, bus.out_valid}, 32'd0);

    // MUL timing: result exactly 16 edges after accept
    drive(OP_MUL, 16'h00FF, 16'h0101, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("mul_busy", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
      tick();
    end
    chk("mul_busy15", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    tick();
    chk_out("mul1", 16'hFFFF, 3'b000);
    chk("mul_rdy", {31'd0, bus.in_ready}, 32'd1);
    drive(OP_MUL, 16'h0100, 16'h0100, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("mul2_drain", {31'd0, bus.out_valid}, 32'd0);
    repeat (15) tick();
    chk("mul2_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk_out("mul2", 16'h0000, 3'b110);

    // Backpressure, then drain + accept on one edge
    drive(OP_ADD, 16'h1234, 16'h1111, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    drive(OP_XOR, 16'h00FF, 16'h0F0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("bp_hold", 16'h2346, 3'b000);
      chk("bp_rdy", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk_out("bp_swap", 16'h0FF0, 3'b000);

    // Accumulator
    drive(OP_ACC, 16'h0005, 16'h0000, 1'b1);
    tick();
    chk_out("acc_ld", 16'h0005, 3'b000);
    drive(OP_ACC, 16'h0003, 16'h0000, 1'b0);
    tick();
    chk_out("acc_add", 16'h0008, 3'b000);
    drive(OP_ACC, 16'hFFF8, 16'h0000, 1'b0);
    tick();
    chk_out("acc_wrap", 16'h0000, 3'b110);
    bus.in_valid = 1'b0;
    tick();

    // Reset in the middle of a multiply
    drive(OP_ACC, 16'h0009, 16'h0000, 1'b1);
    tick();
    drive(OP_MUL, 16'h1234, 16'h0010, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("rmul_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rmul_res", {16'd0, bus.result}, 32'd0);
    chk("rmul_flg", {29'd0, flags()}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rmul_rdy", {31'd0, bus.in_ready}, 32'd1);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) stray++;
    end
    chk("rmul_stray", stray, 32'd0);
    // Accumulator must have been cleared by the reset
    drive(OP_ACC, 16'h0007, 16'h0000, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk_out("acc_rst", 16'h0007, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
